down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/timer_pkg.sv | 16 +
 rtl/down_timer_if.sv | 26 ++
 rtl/down_timer.sv | 94 +++++++++
 tb/tb_down_timer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared timer types: the FSM state encoding and the count-mode flag.
// Sibling timer blocks reuse these types.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } timer_state_e;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } timer_mode_e;

endpackage

// File: rtl/down_timer_if.sv
// Bundle of the down_timer control and status signals.
// The controller side drives commands and the timer side returns status.
interface down_timer_if #(
    parameter int WIDTH = 10
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             clear;
    logic             en;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load, load_value, start, stop, clear, en, periodic,
        input  count, busy, done
    );

    modport slave (
        input  load, load_value, start, stop, clear, en, periodic,
        output count, busy, done
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot or auto-reload modes, pause/resume,
// and a registered single-cycle done pulse on terminal count.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_periodic,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_e     state_q,  state_d;
    timer_mode_e      mode_q,   mode_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q,   done_d;

    // One action per cycle. A stop outside RUN still claims the cycle, so a
    // start arriving alongside it is not taken.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (i_load) begin
            count_d  = i_load_value;
            reload_d = i_load_value;
            state_d  = ST_IDLE;
        end else if (i_clear) begin
            count_d = CNT_ZERO;
            state_d = ST_IDLE;
        end else if (i_stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (i_start && (state_q != ST_RUN)) begin
            if (count_q != CNT_ZERO) begin
                state_d = ST_RUN;
                mode_d  = timer_mode_e'(i_periodic);
            end
        end else if ((state_q == ST_RUN) && i_en) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
                done_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    count_d = reload_q;
                end else begin
                    count_d = CNT_ZERO;
                    state_d = ST_IDLE;
                end
            end else begin
                // Running with a zero count cannot make progress; park it.
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ONESHOT;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign o_count = count_q;
    assign o_busy  = (state_q == ST_RUN);
    assign o_done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed-vector bench for down_timer: the driver queues hand-computed
// expectations, and a separate monitor compares them after each clock edge.
module tb_down_timer;

    localparam int WIDTH = 10;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             done;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   pushed  = 0;

    down_timer_if #(.WIDTH(WIDTH)) tif ();

    down_timer #(.WIDTH(WIDTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load       (tif.load),
        .i_load_value (tif.load_value),
        .i_start      (tif.start),
        .i_stop       (tif.stop),
        .i_clear      (tif.clear),
        .i_en         (tif.en),
        .i_periodic   (tif.periodic),
        .o_count      (tif.count),
        .o_busy       (tif.busy),
        .o_done       (tif.done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic drv(input string nm, input logic r, input logic ld, input int lv,
                       input logic sa, input logic so, input logic cl, input logic en,
                       input logic per, input int ec, input logic eb, input logic ed);
        exp_t e;
        @(negedge clk);
        rst            = r;
        tif.load       = ld;
        tif.load_value = lv[WIDTH-1:0];
        tif.start      = sa;
        tif.stop       = so;
        tif.clear      = cl;
        tif.en         = en;
        tif.periodic   = per;
        e.name  = nm;
        e.count = ec[WIDTH-1:0];
        e.busy  = eb;
        e.done  = ed;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (tif.count !== e.count || tif.busy !== e.busy || tif.done !== e.done) begin
                    errors++;
                    $display("FAIL %s: got count=%0d busy=%0b done=%0b, required count=%0d busy=%0b done=%0b",
                             e.name, tif.count, tif.busy, tif.done, e.count, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1;
        tif.load = 1'b0; tif.load_value = '0; tif.start = 1'b0; tif.stop = 1'b0;
        tif.clear = 1'b0; tif.en = 1'b0; tif.periodic = 1'b0;

        //   name          rst ld lv  sa so cl en per  cnt busy done
        drv("reset0",      1, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0);
        drv("reset1",      1, 0, 0,  0, 0, 0, 1, 0,   0, 0, 0);
        drv("start_cnt0",  0, 0, 0,  1, 0, 0, 1, 0,   0, 0, 0);

        // one-shot from 5
        drv("os_load",     0, 1, 5,  0, 0, 0, 0, 0,   5, 0, 0);
        drv("os_start",    0, 0, 0,  1, 0, 0, 0, 0,   5, 1, 0);
        drv("os_t4",       0, 0, 0,  0, 0, 0, 1, 0,   4, 1, 0);
        drv("os_t3",       0, 0, 0,  0, 0, 0, 1, 0,   3, 1, 0);
        drv("os_t2",       0, 0, 0,  0, 0, 0, 1, 0,   2, 1, 0);
        drv("os_t1",       0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 0);
        drv("os_t0",       0, 0, 0,  0, 0, 0, 1, 0,   0, 0, 1);
        drv("os_idle",     0, 0, 0,  0, 0, 0, 1, 0,   0, 0, 0);

        // periodic from 3; mode latched at start, i_periodic dropped afterwards
        drv("per_load",    0, 1, 3,  0, 0, 0, 0, 0,   3, 0, 0);
        drv("per_start",   0, 0, 0,  1, 0, 0, 0, 1,   3, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drv("per_t2",  0, 0, 0,  0, 0, 0, 1, 0,   2, 1, 0);
            drv("per_t1",  0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 0);
            drv("per_rld", 0, 0, 0,  0, 0, 0, 1, 0,   3, 1, 1);
        end
        drv("per_stop",    0, 0, 0,  0, 1, 0, 1, 0,   3, 0, 0);

        // pause / resume from 10
        drv("pr_load",     0, 1, 10, 0, 0, 0, 0, 0,  10, 0, 0);
        drv("pr_start",    0, 0, 0,  1, 0, 0, 0, 0,  10, 1, 0);
        drv("pr_t9",       0, 0, 0,  0, 0, 0, 1, 0,   9, 1, 0);
        drv("pr_t8",       0, 0, 0,  0, 0, 0, 1, 0,   8, 1, 0);
        drv("pr_t7",       0, 0, 0,  0, 0, 0, 1, 0,   7, 1, 0);
        drv("pr_t6",       0, 0, 0,  0, 0, 0, 1, 0,   6, 1, 0);
        drv("pr_stop",     0, 0, 0,  0, 1, 0, 1, 0,   6, 0, 0);
        for (int k = 0; k < 5; k++)
            drv("pr_hold", 0, 0, 0,  0, 0, 0, 1, 0,   6, 0, 0);
        drv("pr_resume",   0, 0, 0,  1, 0, 0, 0, 0,   6, 1, 0);
        drv("pr_t5",       0, 0, 0,  0, 0, 0, 1, 0,   5, 1, 0);
        drv("pr_clear",    0, 0, 0,  0, 0, 1, 1, 0,   0, 0, 0);

        // start together with stop in IDLE stays IDLE
        drv("ss_load",     0, 1, 8,  0, 0, 0, 0, 0,   8, 0, 0);
        drv("ss_both",     0, 0, 0,  1, 1, 0, 1, 0,   8, 0, 0);
        drv("ss_after",    0, 0, 0,  0, 0, 0, 1, 0,   8, 0, 0);

        // clear on the terminal tick wins and suppresses done
        drv("ct_load",     0, 1, 2,  0, 0, 0, 0, 0,   2, 0, 0);
        drv("ct_start",    0, 0, 0,  1, 0, 0, 0, 0,   2, 1, 0);
        drv("ct_t1",       0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 0);
        drv("ct_clear",    0, 0, 0,  0, 0, 1, 1, 0,   0, 0, 0);
        drv("ct_nodone",   0, 0, 0,  0, 0, 0, 1, 0,   0, 0, 0);
        drv("ct_restart",  0, 0, 0,  1, 0, 0, 1, 0,   0, 0, 0);

        // stop on the terminal tick wins; resume then finishes the count
        drv("st_load",     0, 1, 2,  0, 0, 0, 0, 0,   2, 0, 0);
        drv("st_start",    0, 0, 0,  1, 0, 0, 0, 0,   2, 1, 0);
        drv("st_t1",       0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 0);
        drv("st_stop",     0, 0, 0,  0, 1, 0, 1, 0,   1, 0, 0);
        drv("st_resume",   0, 0, 0,  1, 0, 0, 0, 0,   1, 1, 0);
        drv("st_t0",       0, 0, 0,  0, 0, 0, 1, 0,   0, 0, 1);

        // periodic reload of 1 pulses done on every enabled cycle
        drv("p1_load",     0, 1, 1,  0, 0, 0, 1, 0,   1, 0, 0);
        drv("p1_start",    0, 0, 0,  1, 0, 0, 1, 1,   1, 1, 0);
        drv("p1_a",        0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 1);
        drv("p1_b",        0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 1);
        drv("p1_c",        0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 1);
        drv("p1_noen",     0, 0, 0,  0, 0, 0, 0, 0,   1, 1, 0);
        drv("p1_d",        0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 1);
        drv("p1_stop",     0, 0, 0,  0, 1, 0, 1, 0,   1, 0, 0);

        // load while running returns to IDLE with the new value
        drv("lr_load",     0, 1, 4,  0, 0, 0, 0, 0,   4, 0, 0);
        drv("lr_start",    0, 0, 0,  1, 0, 0, 0, 0,   4, 1, 0);
        drv("lr_t3",       0, 0, 0,  0, 0, 0, 1, 0,   3, 1, 0);
        drv("lr_reload",   0, 1, 9,  0, 0, 0, 1, 0,   9, 0, 0);

        // reset mid-run aborts; start is dead until a new load
        drv("rr_load",     0, 1, 7,  0, 0, 0, 0, 0,   7, 0, 0);
        drv("rr_start",    0, 0, 0,  1, 0, 0, 0, 0,   7, 1, 0);
        drv("rr_t6",       0, 0, 0,  0, 0, 0, 1, 0,   6, 1, 0);
        drv("rr_t5",       0, 0, 0,  0, 0, 0, 1, 0,   5, 1, 0);
        drv("rr_rst",      1, 0, 0,  0, 0, 0, 1, 0,   0, 0, 0);
        drv("rr_start0",   0, 0, 0,  1, 0, 0, 1, 0,   0, 0, 0);
        drv("rr_start1",   0, 0, 0,  1, 0, 0, 0, 0,   0, 0, 0);
        drv("rr_newload",  0, 1, 7,  0, 0, 0, 0, 0,   7, 0, 0);
        drv("rr_newstart", 0, 0, 0,  1, 0, 0, 0, 0,   7, 1, 0);

        // reset on the terminal tick suppresses the pending done
        drv("rd_load",     0, 1, 2,  0, 0, 0, 0, 0,   2, 0, 0);
        drv("rd_start",    0, 0, 0,  1, 0, 0, 0, 0,   2, 1, 0);
        drv("rd_t1",       0, 0, 0,  0, 0, 0, 1, 0,   1, 1, 0);
        drv("rd_rst",      1, 0, 0,  0, 0, 0, 1, 0,   0, 0, 0);
        drv("rd_after",    0, 0, 0,  0, 0, 0, 1, 0,   0, 0, 0);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (checks != pushed) begin
            errors++;
            $display("FAIL drain: %0d of %0d queued expectations were compared", checks, pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
